// File: rtl/mc_bus_responder.sv
// Slave end of the MCU parallel memory-controller bus: synchronizes the async
// strobes and turns each access into one internal register-file strobe.
module mc_bus_responder #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_we,
  input  logic                     mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  output logic [MC_ADD_WIDTH-1:0]  reg_add,
  output logic [MC_DATA_WIDTH-1:0] reg_wdata,
  output logic                     reg_wr_strobe,
  output logic                     reg_rd_strobe,
  input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
  output logic                     bus_error
);

  // state     | meaning
  // IDLE      | waiting for a strobe falling edge with ce low
  // WR_HOLD   | write strobe issued, waiting for we to return high
  // RD_REQ    | read strobe issued, register file data arrives this cycle
  // RD_DRIVE  | driving read data until oe or ce returns high
  // WAIT_IDLE | protocol violation, waiting for we and oe both high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_HOLD   = 3'd1;
  localparam logic [2:0] RD_REQ    = 3'd2;
  localparam logic [2:0] RD_DRIVE  = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] ce_sr, we_sr, oe_sr;
  logic                   ce_s, we_s, oe_s;
  logic                   we_prev, oe_prev;
  logic                   we_fall, oe_fall;
  logic [FW-1:0]          flush_cnt;
  logic                   flushed;
  logic [2:0]             state;

  always_ff @(posedge clock) begin
    if (reset) begin
      ce_sr <= '1;
      we_sr <= '1;
      oe_sr <= '1;
    end else begin
      ce_sr <= {ce_sr[SYNC_STAGES-2:0], mc_ce};
      we_sr <= {we_sr[SYNC_STAGES-2:0], mc_we};
      oe_sr <= {oe_sr[SYNC_STAGES-2:0], mc_oe};
    end
  end

  assign ce_s = ce_sr[SYNC_STAGES-1];
  assign we_s = we_sr[SYNC_STAGES-1];
  assign oe_s = oe_sr[SYNC_STAGES-1];

  // Edge history stays low until the chains hold real pad values, so a strobe
  // held low across reset must be seen high before it can fall again.
  assign flushed = (flush_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      flush_cnt <= FLUSH_INIT;
      we_prev   <= 1'b0;
      oe_prev   <= 1'b0;
    end else begin
      if (!flushed) flush_cnt <= flush_cnt - 1'b1;
      we_prev <= flushed & we_s;
      oe_prev <= flushed & oe_s;
    end
  end

  assign we_fall = ~we_s & we_prev;
  assign oe_fall = ~oe_s & oe_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mc_data_out   <= '0;
      mc_data_oe    <= 1'b0;
      reg_add       <= '0;
      reg_wdata     <= '0;
      reg_wr_strobe <= 1'b0;
      reg_rd_strobe <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      reg_wr_strobe <= 1'b0;
      reg_rd_strobe <= 1'b0;
      bus_error     <= 1'b0;
      case (state)
        IDLE: begin
          if (!ce_s) begin
            if (!we_s && !oe_s && (we_fall || oe_fall)) begin
              bus_error <= 1'b1;
              state     <= WAIT_IDLE;
            end else if (we_fall && oe_s) begin
              reg_add       <= mc_add;
              reg_wdata     <= mc_data_in;
              reg_wr_strobe <= 1'b1;
              state         <= WR_HOLD;
            end else if (oe_fall && we_s) begin
              reg_add       <= mc_add;
              reg_rd_strobe <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_HOLD: begin
          if (ce_s || we_s) state <= IDLE;
        end
        RD_REQ: begin
          if (ce_s) begin
            state <= IDLE;
          end else begin
            mc_data_out <= reg_rdata;
            mc_data_oe  <= 1'b1;
            state       <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (ce_s || oe_s) begin
            mc_data_oe <= 1'b0;
            state      <= IDLE;
          end
        end
        WAIT_IDLE: begin
          if (ce_s || (we_s && oe_s)) state <= IDLE;
        end
        default: begin
          mc_data_oe <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
